// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU fetch definitions: instruction size, PC alignment mask and the
// fetch queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  // Entry fields are sized for the widest PC/instruction the core supports.
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Clears the byte-offset bits of a PC; wide enough for any ADDR_W up to 64.
  localparam logic [63:0] PC_ALIGN_MASK = ~64'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Circular DEPTH-entry queue of fetched {pc, instr} with separate allocate
// (tail), fill (oldest unfilled) and pop (head) pointers.
// Latency: allocate/fill visible at head the cycle after the write.
// Backpressure: caller must not allocate when full or pop an unfilled head.
// Ports:
//   clk, reset           clock, async active-high reset
//   i_flush              drop every entry and rewind all pointers
//   i_alloc/i_alloc_pc   reserve tail entry for a newly issued request
//   i_fill/i_fill_data   write returned instruction into oldest unfilled entry
//   i_pop                retire head entry
//   o_head_*             head entry contents
//   o_alloc_cnt          allocated entries (0..DEPTH)
//   o_filled_cnt         allocated entries whose instruction has returned
module instr_fetch_unit_fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_alloc,
  input  logic [ADDR_W-1:0]        i_alloc_pc,
  input  logic                     i_fill,
  input  logic [DATA_W-1:0]        i_fill_data,
  input  logic                     i_pop,
  output logic                     o_head_filled,
  output logic [ADDR_W-1:0]        o_head_pc,
  output logic [DATA_W-1:0]        o_head_instr,
  output logic [$clog2(DEPTH):0]   o_alloc_cnt,
  output logic [$clog2(DEPTH):0]   o_filled_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_fill;
  logic [CNT_W-1:0] r_alloc_cnt;
  logic [CNT_W-1:0] r_filled_cnt;

  // Alloc, fill and pop never target the same entry in one cycle: tail is
  // unallocated, fill is allocated-but-empty, head is filled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_fill       <= '0;
      r_alloc_cnt  <= '0;
      r_filled_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_fill       <= '0;
      r_alloc_cnt  <= '0;
      r_filled_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].filled <= 1'b0;
      end
    end else begin
      if (i_alloc) begin
        r_mem[r_tail].pc     <= XLEN'(i_alloc_pc);
        r_mem[r_tail].filled <= 1'b0;
        r_tail               <= r_tail + 1'b1;
      end
      // Responses return in request order, so the oldest unfilled entry is
      // always the one this response belongs to.
      if (i_fill) begin
        r_mem[r_fill].instr  <= XLEN'(i_fill_data);
        r_mem[r_fill].filled <= 1'b1;
        r_fill               <= r_fill + 1'b1;
      end
      if (i_pop) begin
        r_mem[r_head].filled <= 1'b0;
        r_head               <= r_head + 1'b1;
      end
      r_alloc_cnt  <= r_alloc_cnt + CNT_W'(i_alloc) - CNT_W'(i_pop);
      r_filled_cnt <= r_filled_cnt + CNT_W'(i_fill) - CNT_W'(i_pop);
    end
  end

  assign o_head_filled = r_mem[r_head].filled;
  assign o_head_pc     = ADDR_W'(r_mem[r_head].pc);
  assign o_head_instr  = DATA_W'(r_mem[r_head].instr);
  assign o_alloc_cnt   = r_alloc_cnt;
  assign o_filled_cnt  = r_filled_cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: steers the PC register, issues in-order imem requests and
// queues returned instructions for decode.
// Latency: request accepted in cycle N -> earliest decode valid in N+2.
// Backpressure: decode stall fills the queue; full queue gates requests and
//   holds the PC. Redirect flushes; orphan responses are counted and dropped.
// Ports:
//   clk, reset                 clock, async active-high reset
//   pc / pc_next               PC register output / next-value input
//   redirect_valid/_pc         taken branch/jump; flush and restart
//   imem_req_valid/_ready/addr request channel (addr = pc)
//   imem_rsp_valid/_data       in-order response channel, never stalled
//   out_valid/_ready           decode handshake
//   out_instr/_pc/_pc_plus4    head instruction, its PC and PC+4
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             w_accept;
  logic             w_fill;
  logic             w_pop;
  logic             w_kill_active;
  logic             w_head_filled;
  logic [CNT_W-1:0] w_alloc_cnt;
  logic [CNT_W-1:0] w_filled_cnt;
  logic [CNT_W-1:0] r_kill_cnt;

  assign w_kill_active  = (r_kill_cnt != '0);
  assign imem_req_valid = ~reset & ~redirect_valid & (w_alloc_cnt < CNT_W'(DEPTH));
  assign imem_addr      = pc;
  assign w_accept       = imem_req_valid & imem_req_ready;
  // A response in the redirect cycle is never written; it is accounted for
  // in the kill count instead.
  assign w_fill         = imem_rsp_valid & ~w_kill_active & ~redirect_valid;
  assign out_valid      = w_head_filled & ~redirect_valid;
  assign w_pop          = out_valid & out_ready;
  assign out_pc_plus4   = out_pc + ADDR_W'(INSTR_BYTES);

  // The PC register has no enable: holding means feeding pc back.
  always_comb begin
    pc_next = pc;
    if (reset) begin
      pc_next = '0;
    end else if (redirect_valid) begin
      pc_next = redirect_pc & ADDR_W'(PC_ALIGN_MASK);
    end else if (w_accept) begin
      pc_next = pc + ADDR_W'(INSTR_BYTES);
    end
  end

  // Kill count = responses still owed by memory for flushed requests. On a
  // flush every allocated-but-unfilled entry becomes an orphan; a response
  // arriving that same cycle is dropped and so is not owed any more, whether
  // it was an older orphan or one of the entries being flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kill_cnt <= '0;
    end else if (redirect_valid) begin
      r_kill_cnt <= r_kill_cnt + (w_alloc_cnt - w_filled_cnt) - CNT_W'(imem_rsp_valid);
    end else if (imem_rsp_valid & w_kill_active) begin
      r_kill_cnt <= r_kill_cnt - 1'b1;
    end
  end

  instr_fetch_unit_fetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (redirect_valid),
    .i_alloc       (w_accept),
    .i_alloc_pc    (pc),
    .i_fill        (w_fill),
    .i_fill_data   (imem_rsp_data),
    .i_pop         (w_pop),
    .o_head_filled (w_head_filled),
    .o_head_pc     (out_pc),
    .o_head_instr  (out_instr),
    .o_alloc_cnt   (w_alloc_cnt),
    .o_filled_cnt  (w_filled_cnt)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC register and an in-order
// instruction memory model (configurable/random latency and ready).
// Cycle timing: inputs driven at negedge+1, memory at negedge+2, sampling at negedge+3.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, pc_next, redirect_pc, imem_addr, imem_rsp_data;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        out_valid, out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  int fixed_lat  = 1;
  bit rand_lat   = 1'b0;
  bit rand_ready = 1'b0;

  logic [31:0] dlv_pc[$], dlv_instr[$], dlv_p4[$], req_log[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc      = 0;
  int    last_due = 0;

  always #5 clk = ~clk;

  // PC register: loads every cycle, no enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
  endfunction

  // Instruction memory: in-order, at most one response per cycle, reset
  // together with the fetch unit.
  initial begin
    int d;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      imem_req_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (reset) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
        last_due = cyc;
      end else begin
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(mq[0].addr);
          void'(mq.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
          d = cyc + (rand_lat ? int'($urandom_range(1, 3)) : fixed_lat);
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          mq.push_back('{imem_addr, d});
        end
      end
    end
  end

  // Transaction recorder: accepted requests and decode pops.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (!reset && imem_req_valid && imem_req_ready) req_log.push_back(imem_addr);
      if (!reset && out_valid && out_ready) begin
        dlv_pc.push_back(out_pc);
        dlv_instr.push_back(out_instr);
        dlv_p4.push_back(out_pc_plus4);
      end
    end
  end

  task automatic next_cyc();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    dlv_pc.delete(); dlv_instr.delete(); dlv_p4.delete(); req_log.delete();
  endtask

  // Ends at the drive point of the first cycle out of reset.
  task automatic do_reset(input logic ordy);
    @(negedge clk); #1;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = ordy;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL rst_pc_next: got %h expected 0", pc_next); end
  endtask

  task automatic test_sequential();
    rand_ready = 1'b0; rand_lat = 1'b0; fixed_lat = 1;
    do_reset(1'b1);
    #2;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL seq_c0_req_valid: got %b expected 1", imem_req_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL seq_c0_addr: got %h expected 0", imem_addr); end
    n_checks++; if (pc_next !== 32'h4) begin n_fail++; $display("FAIL seq_c0_pc_next: got %h expected 4", pc_next); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_c0_out_valid: got %b expected 0", out_valid); end
    next_cyc(); #2;
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_c1_addr: got %h expected 4", imem_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_c1_out_valid: got %b expected 0", out_valid); end
    next_cyc(); #2;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_c2_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL seq_c2_out_pc: got %h expected 0", out_pc); end
    n_checks++; if (out_instr !== instr_of(32'h0)) begin n_fail++; $display("FAIL seq_c2_out_instr: got %h expected %h", out_instr, instr_of(32'h0)); end
    repeat (10) next_cyc();
    // Deliveries in cycles 2..11: one per cycle once the pipe is full.
    n_checks++; if (dlv_pc.size() != 10) begin n_fail++; $display("FAIL seq_dlv_count: got %0d expected 10", dlv_pc.size()); end
    n_checks++; if (req_log.size() < 8) begin n_fail++; $display("FAIL seq_req_count: got %0d expected >= 8", req_log.size()); end
    for (int i = 0; i < 8 && i < dlv_pc.size(); i++) begin
      n_checks++; if (dlv_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_dlv_pc[%0d]: got %h expected %h", i, dlv_pc[i], 32'(4 * i)); end
      n_checks++; if (dlv_instr[i] !== instr_of(32'(4 * i))) begin n_fail++; $display("FAIL seq_dlv_instr[%0d]: got %h expected %h", i, dlv_instr[i], instr_of(32'(4 * i))); end
    end
    for (int i = 0; i < 8 && i < req_log.size(); i++) begin
      n_checks++; if (req_log[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_stall_full();
    logic [31:0] exp [5];
    exp[0] = 32'h0; exp[1] = 32'h4; exp[2] = 32'h8; exp[3] = 32'hC; exp[4] = 32'h10;
    rand_ready = 1'b0; rand_lat = 1'b0; fixed_lat = 1;
    do_reset(1'b0);
    repeat (4) next_cyc();
    #2;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (pc_next !== 32'h10) begin n_fail++; $display("FAIL full_pc_next: got %h expected 10", pc_next); end
    n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL full_pc: got %h expected 10", imem_addr); end
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL full_head: got valid %b pc %h expected valid 1 pc 0", out_valid, out_pc); end
    next_cyc(); #2;
    n_checks++; if (imem_req_valid !== 1'b0 || pc_next !== 32'h10) begin n_fail++; $display("FAIL full_hold: got valid %b pc_next %h expected 0 / 10", imem_req_valid, pc_next); end
    next_cyc();
    n_checks++; if (req_log.size() != 4) begin n_fail++; $display("FAIL full_req_count: got %0d expected 4", req_log.size()); end
    out_ready = 1'b1;
    repeat (10) next_cyc();
    n_checks++; if (dlv_pc.size() < 5) begin n_fail++; $display("FAIL drain_count: got %0d expected >= 5", dlv_pc.size()); end
    for (int i = 0; i < 5 && i < dlv_pc.size(); i++) begin
      n_checks++; if (dlv_pc[i] !== exp[i] || dlv_instr[i] !== instr_of(exp[i])) begin n_fail++; $display("FAIL drain_order[%0d]: got pc %h instr %h expected pc %h instr %h", i, dlv_pc[i], dlv_instr[i], exp[i], instr_of(exp[i])); end
    end
    n_checks++; if (req_log.size() < 5 || req_log[4] !== 32'h10) begin n_fail++; $display("FAIL resume_addr: got %0d requests, expected fifth at 10", req_log.size()); end
  endtask

  task automatic test_redirect();
    rand_ready = 1'b0; rand_lat = 1'b0; fixed_lat = 3;
    do_reset(1'b1);
    next_cyc();
    next_cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    #2;
    n_checks++; if (pc_next !== 32'h100) begin n_fail++; $display("FAIL redir_pc_next: got %h expected 100", pc_next); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_valid: got %b expected 0", imem_req_valid); end
    next_cyc();
    redirect_valid = 1'b0;
    #2;
    n_checks++; if (imem_addr !== 32'h100 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL redir_restart: got addr %h valid %b expected 100 / 1", imem_addr, imem_req_valid); end
    repeat (8) next_cyc();
    n_checks++; if (dlv_pc.size() < 2) begin n_fail++; $display("FAIL redir_dlv_count: got %0d expected >= 2", dlv_pc.size()); end
    else begin
      n_checks++; if (dlv_pc[0] !== 32'h100 || dlv_p4[0] !== 32'h104) begin n_fail++; $display("FAIL redir_first: got pc %h pc4 %h expected 100 / 104", dlv_pc[0], dlv_p4[0]); end
      n_checks++; if (dlv_instr[0] !== instr_of(32'h100)) begin n_fail++; $display("FAIL redir_first_instr: got %h expected %h", dlv_instr[0], instr_of(32'h100)); end
      n_checks++; if (dlv_pc[1] !== 32'h104 || dlv_instr[1] !== instr_of(32'h104)) begin n_fail++; $display("FAIL redir_second: got pc %h instr %h expected 104 / %h", dlv_pc[1], dlv_instr[1], instr_of(32'h104)); end
    end
  endtask

  task automatic test_redirect_collision();
    rand_ready = 1'b0; rand_lat = 1'b0; fixed_lat = 1;
    do_reset(1'b1);
    next_cyc();
    next_cyc();
    // Head (pc 0) is filled and the response for pc 4 arrives this cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL coll_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (pc_next !== 32'h200) begin n_fail++; $display("FAIL coll_pc_next: got %h expected 200", pc_next); end
    next_cyc();
    redirect_valid = 1'b0;
    repeat (6) next_cyc();
    n_checks++; if (dlv_pc.size() < 1) begin n_fail++; $display("FAIL coll_dlv_count: got %0d expected >= 1", dlv_pc.size()); end
    else begin
      n_checks++; if (dlv_pc[0] !== 32'h200 || dlv_p4[0] !== 32'h204) begin n_fail++; $display("FAIL coll_first_pc: got %h / %h expected 200 / 204", dlv_pc[0], dlv_p4[0]); end
      n_checks++; if (dlv_instr[0] !== instr_of(32'h200)) begin n_fail++; $display("FAIL coll_first_instr: got %h expected %h", dlv_instr[0], instr_of(32'h200)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt [3];
    logic [31:0] start, exp;
    tgt[0] = 32'h0000_1000; tgt[1] = 32'h0000_2002; tgt[2] = 32'hFFFF_FFF6;
    rand_ready = 1'b1; rand_lat = 1'b1;
    do_reset(1'b1);
    start = 32'h0;
    for (int s = 0; s < 4; s++) begin
      clear_logs();
      repeat (40) begin
        next_cyc();
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (s < 3) begin
        next_cyc();
        redirect_valid = 1'b1; redirect_pc = tgt[s]; out_ready = 1'b1;
      end
      next_cyc();
      redirect_valid = 1'b0;
      n_checks++; if (dlv_pc.size() < 3) begin n_fail++; $display("FAIL rand_seg%0d_count: got %0d expected >= 3", s, dlv_pc.size()); end
      for (int i = 0; i < dlv_pc.size(); i++) begin
        exp = start + 32'(4 * i);
        n_checks++; if (dlv_pc[i] !== exp) begin n_fail++; $display("FAIL rand_seg%0d_pc[%0d]: got %h expected %h", s, i, dlv_pc[i], exp); end
        n_checks++; if (dlv_instr[i] !== instr_of(exp)) begin n_fail++; $display("FAIL rand_seg%0d_instr[%0d]: got %h expected %h", s, i, dlv_instr[i], instr_of(exp)); end
        n_checks++; if (dlv_p4[i] !== exp + 32'd4) begin n_fail++; $display("FAIL rand_seg%0d_pc4[%0d]: got %h expected %h", s, i, dlv_p4[i], exp + 32'd4); end
      end
      if (s < 3) start = tgt[s] & 32'hFFFF_FFFC;
    end
    rand_ready = 1'b0; rand_lat = 1'b0;
  endtask

  task automatic test_reset_midflight();
    rand_ready = 1'b0; rand_lat = 1'b0; fixed_lat = 3;
    do_reset(1'b0);
    repeat (4) next_cyc();
    #2;
    n_checks++; if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got out_valid %b req_valid %b expected 1 / 0", out_valid, imem_req_valid); end
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc_next: got %h expected 0", pc_next); end
    next_cyc();
    next_cyc();
    reset = 1'b0; out_ready = 1'b1;
    clear_logs();
    #2;
    n_checks++; if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got addr %h valid %b expected 0 / 1", imem_addr, imem_req_valid); end
    repeat (8) next_cyc();
    n_checks++; if (dlv_pc.size() < 2) begin n_fail++; $display("FAIL mid_dlv_count: got %0d expected >= 2", dlv_pc.size()); end
    else begin
      n_checks++; if (dlv_pc[0] !== 32'h0 || dlv_instr[0] !== instr_of(32'h0)) begin n_fail++; $display("FAIL mid_first: got pc %h instr %h expected 0 / %h", dlv_pc[0], dlv_instr[0], instr_of(32'h0)); end
      n_checks++; if (dlv_pc[1] !== 32'h4 || dlv_instr[1] !== instr_of(32'h4)) begin n_fail++; $display("FAIL mid_second: got pc %h instr %h expected 4 / %h", dlv_pc[1], dlv_instr[1], instr_of(32'h4)); end
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    test_reset();
    test_sequential();
    test_stall_full();
    test_redirect();
    test_redirect_collision();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
